// File: rtl/wb_pkg.sv
// Shared definitions for the write-back queue: widths, the hardwired-zero
// register number and the {addr, data} entry layout held in the queue.
package wb_pkg;

   localparam int AW       = 5;
   localparam int DW       = 32;
   localparam int REG_ZERO = 0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Youngest-first bypass lookup over the write-back queue storage. Walks
// backwards from the entry just before tail and stops after head, so the
// first occupied match found is the most recent pending write.
module wb_match
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH)
) (
   input  wb_entry_t        entries [DEPTH],
   input  logic [DEPTH-1:0] valid,
   input  logic [PW-1:0]    head,
   input  logic [PW-1:0]    tail,
   input  logic [AW-1:0]    addr,
   output logic             hit,
   output logic [DW-1:0]    data
);

   logic [PW-1:0] idx;
   logic          done;

   // Priority search from youngest to oldest; r0 lookups never hit.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      done = 1'b0;
      idx  = '0;
      for (int k = 1; k <= DEPTH; k++) begin
         idx = PW'((int'(tail) - k + DEPTH) % DEPTH);
         if (!done && valid[idx] && (entries[idx].addr == addr) &&
             (addr != AW'(REG_ZERO))) begin
            hit  = 1'b1;
            data = entries[idx].data;
            done = 1'b1;
         end
         if (idx == head) begin
            done = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers up to two results per cycle (load older than
// ALU), drains one per cycle into the register file write port, and offers
// two bypass lookup ports over the pending writes.
// AW/DW must match the wb_pkg constants since entries use wb_entry_t.
module wb_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                       clk,
   input  logic                       rstd,
   input  logic                       alu_valid,
   input  logic [AW-1:0]              alu_addr,
   input  logic [DW-1:0]              alu_data,
   input  logic                       ld_valid,
   input  logic [AW-1:0]              ld_addr,
   input  logic [DW-1:0]              ld_data,
   output logic                       in_ready,
   output logic                       we,
   output logic [AW-1:0]              w_addr,
   output logic [DW-1:0]              w_data,
   input  logic [AW-1:0]              byp_addr1,
   input  logic [AW-1:0]              byp_addr2,
   output logic                       byp_hit1,
   output logic                       byp_hit2,
   output logic [DW-1:0]              byp_data1,
   output logic [DW-1:0]              byp_data2,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       ovf
);

   import wb_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   wb_entry_t        mem [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [CW-1:0]    count_q;
   logic             ovf_q;
   logic             ld_push;
   logic             alu_push;
   logic             ld_acc;
   logic             alu_acc;
   logic             pop;
   logic             drop;
   logic [DEPTH-1:0] occ;
   int               space;
   int               n_acc;

   // Advance a pointer by 0..2 places, wrapping modulo DEPTH.
   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
      int s;
      s = int'(p) + n;
      if (s >= DEPTH) begin
         s = s - DEPTH;
      end
      return PW'(s);
   endfunction

   // Decide which pushes fit once this cycle's pop is accounted for; the ALU
   // result is the first to be dropped when space runs out.
   always_comb begin
      ld_push  = ld_valid && (ld_addr != AW'(REG_ZERO));
      alu_push = alu_valid && (alu_addr != AW'(REG_ZERO));
      pop      = (count_q != '0);
      space    = DEPTH - int'(count_q) + (pop ? 1 : 0);
      ld_acc   = ld_push && (space >= 1);
      alu_acc  = alu_push && (space >= (ld_acc ? 2 : 1));
      drop     = (ld_push && !ld_acc) || (alu_push && !alu_acc);
      n_acc    = (ld_acc ? 1 : 0) + (alu_acc ? 1 : 0);
   end

   // Occupancy mask: an entry is live if its distance from head is below count.
   always_comb begin
      occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ[i] = (((i - int'(head) + DEPTH) % DEPTH) < int'(count_q));
      end
   end

   // Pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!rstd) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (pop) begin
            head <= ptr_add(head, 1);
         end
         tail    <= ptr_add(tail, n_acc);
         count_q <= CW'(int'(count_q) + n_acc - (pop ? 1 : 0));
         if (drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Entry storage; the load lands at tail, the ALU result just after it.
   always_ff @(posedge clk) begin
      if (rstd) begin
         if (ld_acc) begin
            mem[tail] <= '{addr: ld_addr, data: ld_data};
         end
         if (alu_acc) begin
            mem[ld_acc ? ptr_add(tail, 1) : tail] <= '{addr: alu_addr, data: alu_data};
         end
      end
   end

   // Head entry drives the register file port whenever the queue is non-empty.
   always_comb begin
      we       = pop;
      w_addr   = pop ? mem[head].addr : '0;
      w_data   = pop ? mem[head].data : '0;
      in_ready = ((DEPTH - int'(count_q)) >= 2);
      count    = count_q;
      ovf      = ovf_q;
   end

   wb_match #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_match1 (
      .entries (mem),
      .valid   (occ),
      .head    (head),
      .tail    (tail),
      .addr    (byp_addr1),
      .hit     (byp_hit1),
      .data    (byp_data1)
   );

   wb_match #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_match2 (
      .entries (mem),
      .valid   (occ),
      .head    (head),
      .tail    (tail),
      .addr    (byp_addr2),
      .hit     (byp_hit2),
      .data    (byp_data2)
   );

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue (DEPTH=4): single push, dual-push ordering,
// r0 filtering, single-producer steady state, fill/overflow, reset mid-drain.
module tb_wb_queue;

   logic        clk;
   logic        rstd;
   logic        alu_valid;
   logic [4:0]  alu_addr;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   logic        in_ready;
   logic        we;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic [4:0]  byp_addr1;
   logic [4:0]  byp_addr2;
   logic        byp_hit1;
   logic        byp_hit2;
   logic [31:0] byp_data1;
   logic [31:0] byp_data2;
   logic [2:0]  count;
   logic        ovf;

   int testsRun  = 0;
   int testsFail = 0;

   wb_queue #(
      .DEPTH (4),
      .AW    (5),
      .DW    (32)
   ) dut (
      .clk       (clk),
      .rstd      (rstd),
      .alu_valid (alu_valid),
      .alu_addr  (alu_addr),
      .alu_data  (alu_data),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .in_ready  (in_ready),
      .we        (we),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .byp_addr1 (byp_addr1),
      .byp_addr2 (byp_addr2),
      .byp_hit1  (byp_hit1),
      .byp_hit2  (byp_hit2),
      .byp_data1 (byp_data1),
      .byp_data2 (byp_data2),
      .count     (count),
      .ovf       (ovf)
   );

   // Free-running 10ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one cycle of producer inputs, let the edge take them, and return
   // 1ns after the edge with the producers idle again.
   task automatic applyStimulus(input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                                input logic av, input logic [4:0] aa, input logic [31:0] ad);
      ld_valid  = lv;
      ld_addr   = la;
      ld_data   = ldd;
      alu_valid = av;
      alu_addr  = aa;
      alu_data  = ad;
      @(posedge clk);
      #1;
      ld_valid  = 1'b0;
      alu_valid = 1'b0;
   endtask

   // Set both lookup addresses and let the combinational search settle.
   task automatic lookup(input logic [4:0] a1, input logic [4:0] a2);
      byp_addr1 = a1;
      byp_addr2 = a2;
      #1;
   endtask

   initial begin
      rstd      = 1'b0;
      ld_valid  = 1'b0;
      ld_addr   = '0;
      ld_data   = '0;
      alu_valid = 1'b0;
      alu_addr  = '0;
      alu_data  = '0;
      byp_addr1 = 5'd3;
      byp_addr2 = 5'd5;

      // Reset state, observed while rstd is still low.
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("rst_count",    count,     0);
      checkOutput("rst_we",       we,        0);
      checkOutput("rst_w_addr",   w_addr,    0);
      checkOutput("rst_w_data",   w_data,    0);
      checkOutput("rst_hit1",     byp_hit1,  0);
      checkOutput("rst_data1",    byp_data1, 0);
      checkOutput("rst_hit2",     byp_hit2,  0);
      checkOutput("rst_in_ready", in_ready,  1);
      checkOutput("rst_ovf",      ovf,       0);
      rstd = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("post_rst_count", count, 0);

      // Single ALU push into an empty queue.
      applyStimulus(0, 0, 0, 1, 5'd3, 32'h0000_00AA);
      checkOutput("single_we",     we,     1);
      checkOutput("single_w_addr", w_addr, 3);
      checkOutput("single_w_data", w_data, 32'hAA);
      checkOutput("single_count",  count,  1);
      lookup(5'd3, 5'd4);
      checkOutput("single_hit1",  byp_hit1,  1);
      checkOutput("single_data1", byp_data1, 32'hAA);
      checkOutput("single_hit2",  byp_hit2,  0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("single_we_after",    we,    0);
      checkOutput("single_count_after", count, 0);

      // Dual push to the same register: load drains first, bypass sees ALU.
      applyStimulus(1, 5'd5, 32'h11, 1, 5'd5, 32'h22);
      checkOutput("dual_count0", count,  2);
      checkOutput("dual_we0",    we,     1);
      checkOutput("dual_addr0",  w_addr, 5);
      checkOutput("dual_data0",  w_data, 32'h11);
      lookup(5'd5, 5'd5);
      checkOutput("dual_byp1_0", byp_data1, 32'h22);
      checkOutput("dual_byp2_0", byp_data2, 32'h22);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("dual_we1",    we,       1);
      checkOutput("dual_data1",  w_data,   32'h22);
      checkOutput("dual_count1", count,    1);
      checkOutput("dual_hit_pop", byp_hit1, 1);
      checkOutput("dual_byp_pop", byp_data1, 32'h22);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("dual_we2",    we,       0);
      checkOutput("dual_hit2",   byp_hit1, 0);

      // Writes to r0 are filtered out entirely.
      applyStimulus(0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
      lookup(5'd0, 5'd0);
      checkOutput("r0_count", count,    0);
      checkOutput("r0_we",    we,       0);
      checkOutput("r0_hit1",  byp_hit1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("r0_we_later", we, 0);

      // A single producer every cycle holds the queue at one entry.
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(0, 0, 0, 1, 5'd9, 32'h900 + i);
         checkOutput("steady_count", count,  1);
         checkOutput("steady_data",  w_data, 32'h900 + i);
         checkOutput("steady_ready", in_ready, 1);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("steady_drained", count, 0);

      // Fill with dual pushes; the fourth one overflows and loses its ALU result.
      applyStimulus(1, 5'd1, 32'h101, 1, 5'd2, 32'h102);
      checkOutput("fill_count1", count,    2);
      checkOutput("fill_ready1", in_ready, 1);
      applyStimulus(1, 5'd3, 32'h103, 1, 5'd4, 32'h104);
      checkOutput("fill_count2", count,    3);
      checkOutput("fill_ready2", in_ready, 0);
      applyStimulus(1, 5'd5, 32'h105, 1, 5'd8, 32'h108);
      checkOutput("fill_count3", count, 4);
      checkOutput("fill_ovf3",   ovf,   0);
      applyStimulus(1, 5'd6, 32'h106, 1, 5'd7, 32'h107);
      checkOutput("ovf_count",  count,  4);
      checkOutput("ovf_set",    ovf,    1);
      checkOutput("ovf_w_addr", w_addr, 4);
      checkOutput("ovf_w_data", w_data, 32'h104);
      lookup(5'd6, 5'd7);
      checkOutput("ovf_hit_ld",   byp_hit1,  1);
      checkOutput("ovf_data_ld",  byp_data1, 32'h106);
      checkOutput("ovf_hit_alu",  byp_hit2,  0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("drain_addr1",  w_addr, 5);
      checkOutput("drain_count1", count,  3);
      checkOutput("ovf_sticky",   ovf,    1);

      // Reset for one cycle with three entries still pending.
      rstd = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      rstd = 1'b1;
      lookup(5'd8, 5'd6);
      checkOutput("mid_rst_count", count,    0);
      checkOutput("mid_rst_we",    we,       0);
      checkOutput("mid_rst_hit1",  byp_hit1, 0);
      checkOutput("mid_rst_hit2",  byp_hit2, 0);
      checkOutput("mid_rst_ovf",   ovf,      0);
      checkOutput("mid_rst_ready", in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         checkOutput("mid_rst_no_write", we, 0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue that sits between the result producers (ALU and load unit) and the single write port of the register file. It accepts up to two results per cycle, buffers them in order, and drains one per cycle onto the register file's `we`/`w_addr`/`w_data` port. It also supplies bypass data for register addresses whose write is still pending in the queue, so the decode stage never reads stale register-file contents.

## Interface
**Parameters**
- `DEPTH`, 4: queue entries; must be ≥ 2.
- `AW`, 5: register address width.
- `DW`, 32: data width.

**Ports**
- `clk` in 1: clock; all state changes on the rising edge.
- `rstd` in 1: reset, synchronous, active-low.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_addr` in AW: ALU destination register.
- `alu_data` in DW: ALU result.
- `ld_valid` in 1: load result present this cycle.
- `ld_addr` in AW: load destination register.
- `ld_data` in DW: load data.
- `in_ready` out 1: the queue can accept two pushes this cycle.
- `we` out 1: register-file write enable.
- `w_addr` out AW: register-file write address.
- `w_data` out DW: register-file write data.
- `byp_addr1`, `byp_addr2` in AW: decode-stage read addresses.
- `byp_hit1`, `byp_hit2` out 1: a pending write to the corresponding address exists.
- `byp_data1`, `byp_data2` out DW: data of the youngest pending write to that address.
- `count` out $clog2(DEPTH+1): number of occupied entries.
- `ovf` out 1: sticky overflow flag.

## Operation
- Storage is a circular buffer of {addr, data} entries with head/tail pointers that wrap modulo DEPTH.
- **Push rules**
  - A valid input whose address is 0 is discarded and never enqueued, because r0 is hardwired to zero.
  - If both inputs are valid in the same cycle, the load is enqueued first (older) and the ALU result second.
- **Pop rule:** when `count > 0`, the head entry drives `we=1`, `w_addr`, and `w_data` combinationally and is popped at the next edge. When `count = 0`, `we=0`.
- **Occupancy:** `count_next = count + pushes − pop`. Push and pop in the same cycle are legal at any occupancy.
- **`in_ready`:** `in_ready = (DEPTH − count ≥ 2)`. It depends only on `count`, not on the current pop.
- **Overflow**
  - Producers must not push while `in_ready=0`.
  - If a push would exceed DEPTH after accounting for this cycle's pop, the excess push (the ALU result first) is dropped and `ovf` is set to 1.
  - `ovf` stays at 1 until reset.
- **Bypass**
  - Each port performs a combinational search of the occupied entries only.
  - If several entries match, the youngest (closest to tail) wins.
  - Address 0 never hits.
  - Results being pushed in the current cycle are not visible to the search.
  - The entry being popped is still visible during its pop cycle.
- **Reset:** clears head, tail, `count`, and `ovf`. All pending entries are discarded; this includes a reset asserted mid-drain.

## Timing
- Values while `rstd=0` and after release: `count=0`, `we=0`, `w_addr=0`, `w_data=0`, `byp_hit*=0`, `byp_data*=0`, `in_ready=1`, `ovf=0`.
- Push at edge N: the entry is visible to bypass and to `we` during cycle N+1, and is written to the register file at edge N+1, provided the queue was otherwise empty.
- With both producers pushing every cycle, the queue fills at a net rate of +1 per cycle. `in_ready` falls once `count > DEPTH−2`.
- A single producer pushing every cycle runs at steady state `count=1` with no stalls.
- Bypass outputs have zero latency relative to `byp_addr*` and the current queue contents.

## Structure
- Shared package `wb_pkg`:
  - constants `AW`, `DW`, `REG_ZERO = 0`;
  - typedef `wb_entry_t` = {addr[AW], data[DW]}.
- Sub-module `wb_match`: a DEPTH-entry youngest-first priority search taking entries, a valid mask, head/tail, and a lookup address, and returning hit and data. It is instantiated twice, once per bypass port.
- The queue storage, pointers, and occupancy counter live in `wb_queue` itself.

## Test plan
- **Single push:** ALU push (addr 3, 0x0000_00AA) into an empty queue → next cycle `we=1`, `w_addr=3`, `w_data=0xAA`, `count=1`; the following cycle `we=0`, `count=0`.
- **Dual push ordering:** load (5, 0x11) and ALU (5, 0x22) pushed in the same cycle.
  - Required: writes appear on two consecutive cycles, 0x11 then 0x22.
  - Required: `byp_addr1=5` returns 0x22 during the first drain cycle.
- **r0 filtering:** ALU push to addr 0 with data 0xFFFF_FFFF → `count` stays 0, `we` never asserts, and `byp_hit` for addr 0 stays 0.
- **Fill/back-pressure:** dual pushes on 3 consecutive cycles with DEPTH=4.
  - Required: `in_ready` deasserts once `count=3`.
  - Required: a dual push ignoring `in_ready` drops the ALU result and sets `ovf=1`, which stays set until `rstd=0`.
- **Reset mid-drain:** 3 entries queued, then `rstd=0` for one cycle → `count=0`, `we=0`, `byp_hit*=0`. No further writes occur.
